// File: rtl/vga_pkg.sv
// Shared game-flow definitions for the pong display pipeline.
//   game_state_t : 2-bit game state carried on the bus from pong_game_fsm to
//                  the ball and paddle controllers. The encoding is fixed
//                  because those blocks decode the raw value.
//   DEF_*        : default game parameters. The right goal line is derived
//                  from the screen width and ball size, so it moves with
//                  the display geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    START     = 2'b00,
    PLAY      = 2'b01,
    POINT     = 2'b10,
    GAME_OVER = 2'b11
  } game_state_t;

  localparam int HOR_PIXELS  = 1024;
  localparam int BALL_SIZE   = 15;
  localparam int GOAL_MARGIN = 8;

  localparam int          DEF_WIN_SCORE   = 7;
  localparam int          DEF_PAUSE_TICKS = 120;
  localparam logic [10:0] DEF_GOAL_L      = 11'd8;
  localparam logic [10:0] DEF_GOAL_R      = 11'(HOR_PIXELS - BALL_SIZE - GOAL_MARGIN);

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector. The input is registered once, and rise is
// high for exactly one cycle when the input goes from 0 to 1. A held input
// produces only one pulse. The paddle logic uses this module too.
//   clk  : system clock
//   rst  : synchronous, active-high reset (clears the history register)
//   d    : level input, already synchronous to clk
//   rise : combinational pulse, d & ~d_q
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pong_game_fsm.sv
// Game-flow controller. It drives the game state bus, detects goals from the
// ball x position, keeps both scores, times the serve pause after each point
// and declares the winner.
//   clk         : system clock (pixel clock domain)
//   rst         : synchronous, active-high reset
//   timing_tick : one-cycle frame strobe. Goals and the pause advance only on it
//   start_btn   : debounced start/serve button (level)
//   x_ball      : ball x position from the ball controller
//   state       : game state (game_state_t encoding)
//   score_left  : left player score (saturates at WIN_SCORE)
//   score_right : right player score (saturates at WIN_SCORE)
//   winner      : 0 = left won, 1 = right won. Meaningful only in GAME_OVER
module pong_game_fsm
  import vga_pkg::*;
#(
  parameter int          WIN_SCORE   = DEF_WIN_SCORE,
  parameter int          PAUSE_TICKS = DEF_PAUSE_TICKS,
  parameter logic [10:0] GOAL_L      = DEF_GOAL_L,
  parameter logic [10:0] GOAL_R      = DEF_GOAL_R
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start_btn,
  input  logic [10:0] x_ball,
  output logic [1:0]  state,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        winner
);

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_TICKS - 1);

  game_state_t state_q, state_d;
  logic [7:0]  pause_cnt;
  logic [3:0]  score_l_q, score_r_q;
  logic        winner_q;

  logic start_rise;
  logic goal_for_right, goal_for_left, pause_done, game_won;

  edge_detect u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (start_btn),
    .rise (start_rise)
  );

  // The left-wall check has priority, so at most one player can score on a tick.
  assign goal_for_right = (x_ball <= GOAL_L);
  assign goal_for_left  = !goal_for_right && (x_ball >= GOAL_R);
  assign pause_done     = timing_tick && (pause_cnt == PAUSE_LAST);
  // Scores were updated on the PLAY exit edge, so this test sees the new point.
  assign game_won       = (score_l_q == WIN) || (score_r_q == WIN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= START;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      START:     if (start_rise) state_d = PLAY;
      PLAY:      if (timing_tick && (goal_for_right || goal_for_left)) state_d = POINT;
      POINT:     if (pause_done) state_d = game_won ? GAME_OVER : PLAY;
      GAME_OVER: if (start_rise) state_d = START;
      default:   state_d = START;
    endcase
  end

  // Pause counter, scores and winner. They follow the same state decode as
  // the FSM, so an increment and the PLAY exit happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_cnt <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          score_l_q <= '0;
          score_r_q <= '0;
        end
        PLAY: begin
          // Clearing the counter here means it is already 0 when POINT starts.
          pause_cnt <= '0;
          if (timing_tick) begin
            if (goal_for_right && (score_r_q < WIN))     score_r_q <= score_r_q + 4'd1;
            else if (goal_for_left && (score_l_q < WIN)) score_l_q <= score_l_q + 4'd1;
          end
        end
        POINT: begin
          if (pause_done) begin
            pause_cnt <= '0;
            if (game_won) winner_q <= (score_r_q == WIN);
          end else if (timing_tick) begin
            pause_cnt <= pause_cnt + 8'd1;
          end
        end
        GAME_OVER: begin
          if (start_rise) begin
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 1'b0;
          end
        end
        default: pause_cnt <= '0;
      endcase
    end
  end

  assign state       = state_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Scoreboard bench for pong_game_fsm. Each stimulus cycle runs a behavioural
// model of the game rules and queues the outputs expected after the next
// clock edge. An independent monitor pops one entry per clock edge and
// compares it with the DUT outputs.
module tb_pong_game_fsm;

  localparam int PAUSE  = 120;
  localparam int WIN    = 7;
  localparam int GOAL_L = 8;
  localparam int GOAL_R = 1001;

  // Game phases, using the encoding seen on the state bus.
  localparam int M_START = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       w;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timing_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic [10:0] x_ball = 11'd500;
  logic [1:0]  state;
  logic [3:0]  score_left, score_right;
  logic        winner;

  always #5 clk = ~clk;

  pong_game_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .timing_tick (timing_tick),
    .start_btn   (start_btn),
    .x_ball      (x_ball),
    .state       (state),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner)
  );

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: phase, scores, and the number of ticks left in the pause.
  int m_mode = M_START, m_sl = 0, m_sr = 0, m_w = 0, m_left = 0, m_prev_btn = 0;

  task automatic model(input bit r, input bit t, input bit b, input int x);
    bit rise;
    if (r) begin
      m_mode = M_START; m_sl = 0; m_sr = 0; m_w = 0; m_left = 0; m_prev_btn = 0;
      return;
    end
    rise = b && !m_prev_btn;
    m_prev_btn = b;
    case (m_mode)
      M_START: if (rise) m_mode = M_PLAY;
      M_PLAY: if (t) begin
        if (x <= GOAL_L) begin
          if (m_sr < WIN) m_sr++;
          m_mode = M_POINT; m_left = PAUSE;
        end else if (x >= GOAL_R) begin
          if (m_sl < WIN) m_sl++;
          m_mode = M_POINT; m_left = PAUSE;
        end
      end
      M_POINT: if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_sl == WIN || m_sr == WIN) begin
            m_mode = M_OVER;
            m_w = (m_sr == WIN) ? 1 : 0;
          end else begin
            m_mode = M_PLAY;
          end
        end
      end
      default: if (rise) begin
        m_sl = 0; m_sr = 0; m_w = 0; m_mode = M_START;
      end
    endcase
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input bit r, input bit t, input bit b, input int x);
    obs_t e;
    @(negedge clk);
    rst = r; timing_tick = t; start_btn = b; x_ball = 11'(x);
    model(r, t, b, x);
    e.st = 2'(m_mode); e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.w = 1'(m_w);
    exp_q.push_back(e);
  endtask

  task automatic pause_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 500);
      step(0, 1, 0, 500);
    end
  endtask

  task automatic press();
    step(0, 0, 1, 500);
    step(0, 0, 0, 500);
  endtask

  task automatic goal(input int x);
    step(0, 1, 0, x);
  endtask

  // Monitor: one comparison per clock edge that has a queued expectation.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state, score_left, score_right, winner};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got state=%b sl=%0d sr=%0d win=%b, expected state=%b sl=%0d sr=%0d win=%b",
                   $time, got.st, got.sl, got.sr, got.w, e.st, e.sl, e.sr, e.w);
        end
      end
    end
  end

  initial begin
    bit lvl;
    bit r, t;
    int x, sel;

    // Reset, then start; a held button causes nothing further.
    repeat (3) step(1, 0, 0, 500);
    repeat (2) step(0, 0, 0, 500);
    step(0, 0, 1, 500);
    repeat (50) step(0, 1, 1, 500);
    step(0, 0, 0, 500);

    // Right goal; a stale x_ball during the pause does not score again.
    goal(5);
    for (int i = 0; i < PAUSE; i++) step(0, 1, 0, 5);
    step(0, 0, 0, 500);

    // Left goal, the 1000 near-miss, and the inclusive left boundary.
    goal(1001);
    pause_ticks(PAUSE);
    goal(1000);
    goal(8);
    pause_ticks(PAUSE);

    // Left wins; a later goal position changes nothing.
    for (int i = 0; i < 20 && m_mode != M_OVER; i++) begin
      goal(1001);
      pause_ticks(PAUSE);
    end
    goal(1001);
    repeat (5) step(0, 1, 0, 2047);

    // Restart, then begin play.
    press();
    press();

    // Score 3:2, reset 60 ticks into the pause, then a full pause after restarting.
    goal(1001); pause_ticks(PAUSE);
    goal(1001); pause_ticks(PAUSE);
    goal(1001); pause_ticks(PAUSE);
    goal(0);    pause_ticks(PAUSE);
    goal(3);
    pause_ticks(60);
    step(1, 0, 0, 500);
    step(0, 0, 0, 500);
    press();
    goal(5);
    pause_ticks(PAUSE - 1);
    step(0, 0, 0, 500);
    step(0, 1, 0, 500);
    step(0, 0, 0, 500);

    // Randomized play: sparse ticks, toggling button, goals and boundary values.
    lvl = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      r = ($urandom_range(0, 2999) == 0);
      t = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) lvl = ~lvl;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       x = $urandom_range(0, GOAL_L);
        1:       x = $urandom_range(GOAL_R, 2047);
        2: begin
          case ($urandom_range(0, 3))
            0:       x = GOAL_L;
            1:       x = GOAL_L + 1;
            2:       x = GOAL_R - 1;
            default: x = GOAL_R;
          endcase
        end
        default: x = $urandom_range(GOAL_L + 1, GOAL_R - 1);
      endcase
      step(r, t, lvl, x);
    end

    @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
